// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line scheduler.
package vga_pkg;

    // BGR555 pixel: [14:10] blue, [9:5] green, [4:0] red
    typedef logic [14:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int unsigned VGA_HPIX      = 512;
    localparam int unsigned NES_HPIX      = 256;
    localparam int unsigned VTOTAL_DEFAULT = 524;

    // Colour of test-pattern bar idx: white, yellow, cyan, green, magenta, red, blue, black
    function automatic pixel_t bar_color(input logic [2:0] idx);
        logic b, g, r;
        b = ~idx[1] ^ idx[2] ? 1'b0 : 1'b0;
        case (idx)
            3'd0:    {b, g, r} = 3'b111;
            3'd1:    {b, g, r} = 3'b011;
            3'd2:    {b, g, r} = 3'b110;
            3'd3:    {b, g, r} = 3'b010;
            3'd4:    {b, g, r} = 3'b101;
            3'd5:    {b, g, r} = 3'b001;
            3'd6:    {b, g, r} = 3'b100;
            default: {b, g, r} = 3'b000;
        endcase
        return {{5{b}}, {5{g}}, {5{r}}};
    endfunction

endpackage

// File: rtl/line_buf_2x256.sv
// Two-bank 256-entry scanline RAM: one write port, one synchronous read port,
// read-before-write on address collision. Written to map onto block RAM.
module line_buf_2x256
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [8:0] waddr,
    input  pixel_t     wdata,
    input  logic [8:0] raddr,
    output pixel_t     rdata
);

    pixel_t mem [0:511];
    pixel_t rdata_q;

    // Single clocked block so the read samples the old word when addresses collide
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_line_scheduler.sv
// Ping-pong scanline controller between the PPU pixel stream and VgaDriver.
// The PPU writes one line into the bank picked by ppu_y[0] while VgaDriver
// replays the other bank with every NES pixel doubled horizontally. An FSM
// keeps VgaDriver frame-locked by pulsing sync at PPU frame start.
// Optional build macro: VGA_TESTPAT_EN shows colour bars instead of black
// while the FSM is not in RUN.
module vga_line_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned VTOTAL   = VTOTAL_DEFAULT,
    parameter int unsigned LOCK_TOL = 2,
    parameter int unsigned MISS_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ppu_we,
    input  logic [7:0]  ppu_x,
    input  logic [8:0]  ppu_y,
    input  logic [14:0] ppu_pixel,
    input  logic        ppu_frame_start,
    input  logic [9:0]  next_pixel_x,
    input  logic [9:0]  vga_vcounter,
    output logic [14:0] pixel,
    output logic        sync,
    output logic        locked,
    output logic        underrun
);

    localparam int unsigned MISS_W  = $clog2(MISS_MAX + 1);
    localparam logic [9:0]  V_LAST  = 10'(VTOTAL - 1);
    localparam logic [9:0]  V_LOW   = 10'(LOCK_TOL);
    localparam logic [9:0]  V_HIGH  = 10'(VTOTAL - LOCK_TOL);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

    state_t            state_q, state_d;
    logic              locked_q, locked_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d, miss_inc;
    logic              wr_bank_q, wr_bank_d;
    logic              underrun_q, underrun_d;
    logic              sync_prev_q;
    logic              sync_req;
    logic              in_tol;
    pixel_t            rd_pixel;

    // Only the horizontally-halved column and the bank bit of the line are needed
    logic unused_bits;
    assign unused_bits = ^{next_pixel_x[9], next_pixel_x[0], ppu_y[8:1]};

    line_buf_2x256 u_buf (
        .clk   (clk),
        .we    (ppu_we),
        .waddr ({ppu_y[0], ppu_x}),
        .wdata (ppu_pixel),
        .raddr ({~wr_bank_q, next_pixel_x[8:1]}),
        .rdata (rd_pixel)
    );

    // Next-state logic for lock FSM, bank tracking and underrun detection
    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        miss_cnt_d = miss_cnt_q;
        sync_req   = 1'b0;
        in_tol     = (vga_vcounter <= V_LOW) || (vga_vcounter >= V_HIGH);
        miss_inc   = (miss_cnt_q >= MISS_LIM) ? MISS_LIM : miss_cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (ppu_frame_start) begin
                    sync_req   = 1'b1;
                    miss_cnt_d = '0;
                    state_d    = LOCKING;
                end
            end
            LOCKING: begin
                // A fresh frame start wins over the end-of-frame line: restart the lock
                if (ppu_frame_start) begin
                    sync_req   = 1'b1;
                    miss_cnt_d = '0;
                end else if (vga_vcounter == V_LAST) begin
                    state_d  = RUN;
                    locked_d = 1'b1;
                end
            end
            RUN: begin
                if (ppu_frame_start) begin
                    if (in_tol) begin
                        miss_cnt_d = '0;
                    end else if (miss_inc >= MISS_LIM) begin
                        sync_req   = 1'b1;
                        locked_d   = 1'b0;
                        miss_cnt_d = '0;
                        state_d    = LOCKING;
                    end else begin
                        miss_cnt_d = miss_inc;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                locked_d = 1'b0;
            end
        endcase

        wr_bank_d  = ppu_we ? ppu_y[0] : wr_bank_q;
        underrun_d = underrun_q | (ppu_we & (ppu_y[0] == ~wr_bank_q));
    end

    // Control state registers; buffer contents are deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            locked_q    <= 1'b0;
            miss_cnt_q  <= '0;
            wr_bank_q   <= 1'b0;
            underrun_q  <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            miss_cnt_q  <= miss_cnt_d;
            wr_bank_q   <= wr_bank_d;
            underrun_q  <= underrun_d;
            sync_prev_q <= sync;
        end
    end

    // sync lands in the same cycle as the frame-start pulse and never runs two cycles
    assign sync     = sync_req & ~reset & ~sync_prev_q;
    assign locked   = locked_q;
    assign underrun = underrun_q;

`ifdef VGA_TESTPAT_EN
    logic [2:0] bar_q;

    // Bar index delayed one cycle to line up with the RAM read latency
    always_ff @(posedge clk) begin
        bar_q <= next_pixel_x[8:6];
    end

    assign pixel = (state_q == RUN) ? rd_pixel : bar_color(bar_q);
`else
    assign pixel = (state_q == RUN) ? rd_pixel : '0;
`endif

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Self-checking bench for vga_line_scheduler: frame lock, line replay,
// drift tolerance, re-sync, underrun and mid-frame reset.
module tb_vga_line_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        ppu_we;
    logic [7:0]  ppu_x;
    logic [8:0]  ppu_y;
    logic [14:0] ppu_pixel;
    logic        ppu_frame_start;
    logic [9:0]  next_pixel_x;
    logic [9:0]  vga_vcounter;
    logic [14:0] pixel;
    logic        sync;
    logic        locked;
    logic        underrun;

    int total = 0;
    int bad   = 0;
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    vga_line_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .ppu_we          (ppu_we),
        .ppu_x           (ppu_x),
        .ppu_y           (ppu_y),
        .ppu_pixel       (ppu_pixel),
        .ppu_frame_start (ppu_frame_start),
        .next_pixel_x    (next_pixel_x),
        .vga_vcounter    (vga_vcounter),
        .pixel           (pixel),
        .sync            (sync),
        .locked          (locked),
        .underrun        (underrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pixel while not in RUN, for a next_pixel_x held for at least one cycle
    function automatic logic [14:0] idle_px(input logic [9:0] npx);
`ifdef VGA_TESTPAT_EN
        logic [14:0] tbl [0:7];
        tbl[0] = 15'h7FFF; tbl[1] = 15'h03FF; tbl[2] = 15'h7FE0; tbl[3] = 15'h03E0;
        tbl[4] = 15'h7C1F; tbl[5] = 15'h001F; tbl[6] = 15'h7C00; tbl[7] = 15'h0000;
        return tbl[npx[8:6]];
`else
        return (npx == 10'h3FF) ? 15'h0 : 15'h0;
`endif
    endfunction

    task automatic pop_chk(input string tag);
        logic [14:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {17'd0, pixel}, {17'd0, e});
        end
    endtask

    task automatic write_px(input logic [8:0] y, input logic [7:0] x, input logic [14:0] p);
        ppu_we = 1'b1; ppu_y = y; ppu_x = x; ppu_pixel = p;
        tick();
        ppu_we = 1'b0;
    endtask

    // One frame-start pulse at the given line; sync checked in the pulse cycle
    task automatic frame_start(input logic [9:0] v, input logic exp_sync, input string tag);
        vga_vcounter = v;
        ppu_frame_start = 1'b1;
        #1;
        chk({tag, "_sync"}, {31'd0, sync}, {31'd0, exp_sync});
        tick();
        ppu_frame_start = 1'b0;
        #1;
        chk({tag, "_sync_after"}, {31'd0, sync}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; ppu_we = 1'b0; ppu_x = '0; ppu_y = '0; ppu_pixel = '0;
        ppu_frame_start = 1'b0; next_pixel_x = '0; vga_vcounter = 10'd100;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_pixel",    {17'd0, pixel}, {17'd0, idle_px(10'd0)});
        chk("rst_sync",     {31'd0, sync}, 32'd0);
        chk("rst_locked",   {31'd0, locked}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);

        // Frame start at cycle 10 after reset release; no lock until line 523
        repeat (9) tick();
        frame_start(10'd100, 1'b1, "t1_first");
        repeat (4) tick();
        chk("t1_locking_sync", {31'd0, sync}, 32'd0);
        chk("t1_not_locked", {31'd0, locked}, 32'd0);
        // Frame start coinciding with the last line: resync takes priority
        frame_start(10'd523, 1'b1, "t1_resync");
        chk("t1_resync_unlocked", {31'd0, locked}, 32'd0);
        vga_vcounter = 10'd523;
        tick();
        chk("t1_locked", {31'd0, locked}, 32'd1);
        vga_vcounter = 10'd10;

        // Fill bank 0 with pixel=x, then bank 1; first bank-1 write collides with read bank
        for (int x = 0; x < 256; x++) write_px(9'd0, 8'(x), 15'(x));
        chk("t5_no_underrun", {31'd0, underrun}, 32'd0);
        write_px(9'd1, 8'd0, 15'h4000);
        chk("t5_underrun_set", {31'd0, underrun}, 32'd1);
        for (int x = 1; x < 256; x++) write_px(9'd1, 8'(x), 15'h4000 | 15'(x));

        // Replay bank 0 doubled: 2k and 2k+1 give pixel k
        next_pixel_x = 10'd0;
        exp_q.push_back(15'd0);
        for (int i = 1; i <= 512; i++) begin
            tick();
            pop_chk("t2_replay");
            if (i < 512) begin
                next_pixel_x = 10'(i);
                exp_q.push_back(15'(i >> 1));
            end
        end

        // Same-address write and read: read sees the old word
        ppu_we = 1'b1; ppu_y = 9'd2; ppu_x = 8'd5; ppu_pixel = 15'h7ABC;
        next_pixel_x = 10'd10;
        exp_q.push_back(15'd5);
        tick();
        ppu_we = 1'b0;
        pop_chk("rbw_old");
        // wr_bank is now 0, so bank 1 is replayed
        exp_q.push_back(15'h4005);
        tick();
        pop_chk("bank1_read");
        write_px(9'd3, 8'd0, 15'h4000);
        exp_q.push_back(15'h7ABC);
        tick();
        pop_chk("rbw_new");
        chk("t5_underrun_sticky", {31'd0, underrun}, 32'd1);

        // Frame starts inside tolerance keep the lock
        frame_start(10'd523, 1'b0, "t3_v523");
        chk("t3_locked_a", {31'd0, locked}, 32'd1);
        tick();
        frame_start(10'd2, 1'b0, "t3_v2");
        chk("t3_locked_b", {31'd0, locked}, 32'd1);
        // Two misses, then an in-tolerance start clears the count
        frame_start(10'd3, 1'b0, "t3_v3");
        frame_start(10'd521, 1'b0, "t3_v521");
        frame_start(10'd522, 1'b0, "t3_v522");
        chk("t3_locked_c", {31'd0, locked}, 32'd1);

        // Three consecutive misses: sync only on the third, then unlock
        frame_start(10'd100, 1'b0, "t4_m1");
        tick();
        frame_start(10'd100, 1'b0, "t4_m2");
        chk("t4_still_locked", {31'd0, locked}, 32'd1);
        tick();
        next_pixel_x = 10'd200;
        frame_start(10'd100, 1'b1, "t4_m3");
        chk("t4_unlocked", {31'd0, locked}, 32'd0);
        tick();
        chk("t4_pixel_idle", {17'd0, pixel}, {17'd0, idle_px(10'd200)});
        vga_vcounter = 10'd523;
        tick();
        chk("t4_relocked", {31'd0, locked}, 32'd1);
        vga_vcounter = 10'd50;

        // Reset mid-line while running
        next_pixel_x = 10'd300;
        tick();
        reset = 1'b1;
        ppu_frame_start = 1'b1;
        #1;
        chk("t6_sync_in_reset", {31'd0, sync}, 32'd0);
        tick();
        ppu_frame_start = 1'b0;
        chk("t6_locked", {31'd0, locked}, 32'd0);
        chk("t6_pixel", {17'd0, pixel}, {17'd0, idle_px(10'd300)});
        chk("t6_underrun_clr", {31'd0, underrun}, 32'd0);
        reset = 1'b0;
        vga_vcounter = 10'd523;
        repeat (3) tick();
        chk("t6_idle_ignores_v", {31'd0, locked}, 32'd0);
        frame_start(10'd523, 1'b1, "t6_restart");
        tick();
        chk("t6_relock", {31'd0, locked}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
